// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_arb_pkg;

    // Architectural register file: 32 registers, x0 hard-wired to zero.
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_ZERO   = 0;

    // Arbitration mode: NORMAL favours writeback, DRAIN forces one FIFO dequeue.
    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } arb_state_t;

    // Write request record at the default 5-bit index / 32-bit data configuration.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [31:0]           data;
    } wr_req_t;

    // One-hot register mask for a destination index.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input int unsigned idx);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/wr_req_fifo.sv
// Long-unit write buffer: small FIFO with per-entry valid bits so that queued
// writes can be squashed by destination without disturbing FIFO order.
module wr_req_fifo
    import regfile_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push_i,
    input  logic [ADDR_WIDTH-1:0] push_addr_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic                  squash_i,
    input  logic [ADDR_WIDTH-1:0] squash_addr_i,
    output logic                  full_o,
    output logic                  head_live_o,
    output logic                  any_live_o,
    output logic [ADDR_WIDTH-1:0] head_addr_o,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic [NUM_REGS-1:0]   pending_mask_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t            mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_idx, rd_idx;
    logic            empty;
    logic            advance;

    assign wr_idx = wr_ptr_q[PW-1:0];
    assign rd_idx = rd_ptr_q[PW-1:0];

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full_o = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);

    assign head_live_o = !empty && valid_q[rd_idx];
    assign any_live_o  = |valid_q;
    assign head_addr_o = mem_q[rd_idx].addr;
    assign head_data_o = mem_q[rd_idx].data;

    // A squashed head is retired on its own so the next live entry reaches the head.
    assign advance = !empty && (pop_i || !valid_q[rd_idx]);

    // Valid bits: squash existing matches, retire the head, then mark the new entry.
    always_comb begin
        valid_d = valid_q;
        if (squash_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid_q[PW'(i)] && (mem_q[PW'(i)].addr == squash_addr_i)) begin
                    valid_d[PW'(i)] = 1'b0;
                end
            end
        end
        if (advance) begin
            valid_d[rd_idx] = 1'b0;
        end
        // The incoming result is younger than a same-cycle writeback, so it survives.
        if (push_i) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = push_i  ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
        rd_ptr_d = advance ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;
    end

    // OR of destinations of all live entries.
    always_comb begin
        pending_mask_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[PW'(i)]) begin
                pending_mask_o = pending_mask_o | reg_onehot(int'(mem_q[PW'(i)].addr));
            end
        end
    end

    // Control state: reset discards every queued entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage; contents are only meaningful under a valid bit.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_idx] <= '{addr: push_addr_i, data: push_data_i};
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority)
// and buffered long-unit results, with starvation-forced draining and WAW squash.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_stall,
    input  logic                  lu_valid,
    input  logic [ADDR_WIDTH-1:0] lu_rd,
    input  logic [DATA_WIDTH-1:0] lu_data,
    output logic                  lu_ready,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_a,
    output logic [DATA_WIDTH-1:0] rf_wd,
    output logic [NUM_REGS-1:0]   pending_mask
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    arb_state_t            state_q, state_d;
    logic [CW-1:0]         starve_cnt_q, starve_cnt_d;
    logic                  rf_we_q;
    logic [ADDR_WIDTH-1:0] rf_a_q;
    logic [DATA_WIDTH-1:0] rf_wd_q;

    logic                  wb_req;
    logic                  lu_push;
    logic                  sel_wb;
    logic                  sel_fifo;
    logic                  fifo_full;
    logic                  fifo_head_live;
    logic                  fifo_any_live;
    logic [ADDR_WIDTH-1:0] fifo_head_addr;
    logic [DATA_WIDTH-1:0] fifo_head_data;

    // Writes to x0 are dropped at the input; an x0 handshake still completes.
    assign wb_req   = wb_we && (wb_rd != ADDR_WIDTH'(REG_ZERO));
    assign lu_ready = !fifo_full;
    assign lu_push  = lu_valid && lu_ready && (lu_rd != ADDR_WIDTH'(REG_ZERO));

    wr_req_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk            (clk),
        .reset_n        (reset_n),
        .push_i         (lu_push),
        .push_addr_i    (lu_rd),
        .push_data_i    (lu_data),
        .pop_i          (sel_fifo),
        .squash_i       (sel_wb),
        .squash_addr_i  (wb_rd),
        .full_o         (fifo_full),
        .head_live_o    (fifo_head_live),
        .any_live_o     (fifo_any_live),
        .head_addr_o    (fifo_head_addr),
        .head_data_o    (fifo_head_data),
        .pending_mask_o (pending_mask)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enter DRAIN on the edge the counter reaches the limit so the
    // stall lands right after the last permitted writeback win; leave after one
    // dequeue, or if squashes left nothing to drain.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NORMAL: if (starve_cnt_d == CW'(STARVE_LIMIT)) state_d = DRAIN;
            DRAIN:  if (sel_fifo || !fifo_any_live)        state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    // FSM outputs: arbitration select and writeback stall.
    always_comb begin
        sel_wb   = 1'b0;
        sel_fifo = 1'b0;
        wb_stall = 1'b0;
        unique case (state_q)
            NORMAL: begin
                if (wb_req) sel_wb   = 1'b1;
                else        sel_fifo = fifo_head_live;
            end
            DRAIN: begin
                sel_fifo = fifo_head_live;
                wb_stall = wb_req;
            end
            default: ;
        endcase
    end

    // Starvation counter: counts writeback wins over a live FIFO, saturating.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!fifo_any_live || sel_fifo) begin
            starve_cnt_d = '0;
        end else if (sel_wb && (starve_cnt_q != CW'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Write-port register: winner lands one cycle after arbitration; address/data hold when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we_q <= 1'b0;
            rf_a_q  <= '0;
            rf_wd_q <= '0;
        end else begin
            rf_we_q <= sel_wb || sel_fifo;
            if (sel_wb) begin
                rf_a_q  <= wb_rd;
                rf_wd_q <= wb_data;
            end else if (sel_fifo) begin
                rf_a_q  <= fifo_head_addr;
                rf_wd_q <= fifo_head_data;
            end
        end
    end

    assign rf_we = rf_we_q;
    assign rf_a  = rf_a_q;
    assign rf_wd = rf_wd_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single register-file write port that feeds the write decoder's A/WE inputs.
- Shares that port between the in-order pipeline writeback stage and the long-latency unit (multi-cycle mul/div, late load return).
- Long-unit writes are buffered in a small FIFO.
- Writeback has priority; a starvation counter occasionally stalls writeback so queued writes drain.
- WAW hazards are resolved by squashing queued writes that a younger writeback overwrites.

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width (32 registers)
- FIFO_DEPTH, 2, long-unit buffer entries (power of two, at least 2)
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose arbitration before forcing a drain

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- wb_we  input  1  writeback write request
- wb_rd  input  ADDR_WIDTH  writeback destination
- wb_data  input  DATA_WIDTH  writeback data
- wb_stall  output  1  combinational; writeback must hold its request this cycle
- lu_valid  input  1  long-unit result valid
- lu_rd  input  ADDR_WIDTH  long-unit destination
- lu_data  input  DATA_WIDTH  long-unit data
- lu_ready  output  1  FIFO can accept; equals not-full
- rf_we  output  1  registered write enable to register file
- rf_a  output  ADDR_WIDTH  registered write address
- rf_wd  output  DATA_WIDTH  registered write data
- pending_mask  output  32  one-hot OR of rd of every live FIFO entry, for hazard stall logic

Behaviour:
- Reset (asynchronous, reset_n low): rf_we=0, rf_a=0, rf_wd=0, FIFO empty, starve counter=0, state=NORMAL, pending_mask=0.
  - Outputs while in reset: lu_ready=1, wb_stall=0.
  - Reset mid-operation discards all queued entries without writing them.
- Writes to x0 are dropped at input:
  - wb_we with wb_rd=0 is treated as no request.
  - lu handshake with lu_rd=0 completes but nothing is enqueued.
- Long-unit handshake: a transfer occurs when lu_valid && lu_ready at the rising edge.
  - lu_ready depends only on FIFO fullness, never on same-cycle dequeue.
  - lu_valid may be raised regardless of ready; rd and data are held until transfer.
- Arbitration each cycle. Candidates are the writeback request (wb_we, rd != 0) and the FIFO head (FIFO non-empty).
  - NORMAL state: writeback wins if present, otherwise FIFO head. wb_stall=0.
  - DRAIN state: FIFO head wins, and wb_stall=wb_we.
- The winner is registered to rf_we/rf_a/rf_wd. The port is written one cycle after arbitration (fixed latency 1).
  - No winner gives rf_we=0. rf_a and rf_wd hold their previous value.
- Long-unit latency: accepted at edge N, earliest arbitration in cycle N+1, rf_we high in cycle N+2.
- Starve counter:
  - Increments when the FIFO is non-empty and writeback wins.
  - Clears when the FIFO head is dequeued or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- State transitions:
  - NORMAL to DRAIN when counter==STARVE_LIMIT.
  - DRAIN to NORMAL after exactly one FIFO dequeue.
- WAW squash: when writeback wins with rd=R, every live FIFO entry with rd=R is invalidated in the same edge.
  - Squashed entries are skipped at dequeue, and their pending_mask bits clear.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle are both legal.
  - A squash and an enqueue of the same rd in the same cycle: the new entry survives, because the long-unit result is younger.
- Full FIFO: lu_ready=0. Empty FIFO: no dequeue and no counter increment.
- Pointer wrap-around uses an extra MSB bit to distinguish full from empty.

Decomposition:
- Package regfile_arb_pkg:
  - typedef wr_req_t {addr[ADDR_WIDTH], data[DATA_WIDTH]}
  - enum arb_state_t {NORMAL, DRAIN}
  - constants REG_ZERO=0 and NUM_REGS=32
- Sub-module wr_req_fifo holds the FIFO_DEPTH-entry storage:
  - per-entry valid bits, squash-by-address input, and pending-mask generation
  - the top level holds arbitration, the FSM, and the output registers

Test Plan:
- Writeback only: wb_we=1, rd=5, data=0xDEADBEEF for 1 cycle -> next cycle rf_we=1, rf_a=5, rf_wd=0xDEADBEEF. wb_rd=0 -> rf_we stays 0.
- Long unit idle path: lu_valid with rd=7, data=0x12 at edge N -> pending_mask=0x80 from N+1; rf_we/rf_a=7 in cycle N+2; mask returns to 0.
- Starvation: FIFO holds rd=9 and wb_we=1 every cycle -> after 4 writeback wins, wb_stall=1 for one cycle; rf_a=9 the following cycle; wb_stall then returns to 0.
- Full/backpressure: 2 lu transfers while writeback is busy -> lu_ready=0. A third lu_valid is held and transfers only after a dequeue; no data is lost or duplicated.
- WAW squash: FIFO holds rd=3 data=0xAA, then writeback rd=3 data=0xBB wins -> rf_wd=0xBB, pending_mask bit 3 clears, 0xAA is never written.
- Reset mid-operation: FIFO holds 2 entries and reset_n pulses low asynchronously -> rf_we=0, pending_mask=0, lu_ready=1 immediately; no queued write appears after release.
